// File: rtl/pram_pkg.sv
// Shared types and default sizes for the multi-processor write arbiter.
package pram_pkg;

  localparam int DEF_NUM_PORTS        = 4;
  localparam int DEF_DOUBLEWORD_WIDTH = 64;
  localparam int DEF_DATA_MEMORY_SIZE = 1024;
  localparam int DEF_DATA_TYPE_WIDTH  = 2;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE   = 2'b00;
  localparam arb_state_t ST_ACCESS = 2'b01;
  localparam arb_state_t ST_WRITE  = 2'b10;

endpackage

// File: rtl/mp_write_arbiter_if.sv
// Bundle of per-processor write requests and the muxed write port toward data memory.
interface mp_write_arbiter_if import pram_pkg::*; #(
  parameter int NUM_PORTS        = DEF_NUM_PORTS,
  parameter int DOUBLEWORD_WIDTH = DEF_DOUBLEWORD_WIDTH,
  parameter int DATA_MEMORY_SIZE = DEF_DATA_MEMORY_SIZE,
  parameter int ADDR_WIDTH_DM    = $clog2(DATA_MEMORY_SIZE),
  parameter int DATA_TYPE_WIDTH  = DEF_DATA_TYPE_WIDTH
);

  logic [NUM_PORTS*DOUBLEWORD_WIDTH-1:0] data_bus_wr_p;
  logic [NUM_PORTS*ADDR_WIDTH_DM-1:0]    addr_wr_p;
  logic [NUM_PORTS*DATA_TYPE_WIDTH-1:0]  data_type_wr_p;
  logic [NUM_PORTS-1:0]                  wr_ins_p;
  logic [NUM_PORTS-1:0]                  wr_idle_p;
  logic [NUM_PORTS-1:0]                  wr_access_p;
  logic [DOUBLEWORD_WIDTH-1:0]           data_bus_wr_dm;
  logic [ADDR_WIDTH_DM-1:0]              addr_wr_dm;
  logic [DATA_TYPE_WIDTH-1:0]            data_type_wr_dm;
  logic                                  wr_ins_dm;
  logic                                  wr_idle_dm;
  logic                                  arb_busy;

  // Arbiter side
  modport slave (
    input  data_bus_wr_p, addr_wr_p, data_type_wr_p, wr_ins_p, wr_idle_dm,
    output wr_idle_p, wr_access_p, data_bus_wr_dm, addr_wr_dm, data_type_wr_dm,
           wr_ins_dm, arb_busy
  );

  // Processors plus memory write handler side
  modport master (
    output data_bus_wr_p, addr_wr_p, data_type_wr_p, wr_ins_p, wr_idle_dm,
    input  wr_idle_p, wr_access_p, data_bus_wr_dm, addr_wr_dm, data_type_wr_dm,
           wr_ins_dm, arb_busy
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational one-hot winner select. WR_ARB_ROUND_ROBIN_EN selects rotating
// priority from ptr+1; otherwise the lowest eligible index wins.
module rr_priority_picker #(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]         req,
`ifdef WR_ARB_ROUND_ROBIN_EN
  input  logic [$clog2(NUM_PORTS)-1:0] ptr,
`endif
  input  logic [NUM_PORTS-1:0]         exclude,
  output logic [NUM_PORTS-1:0]         winner
);

  logic [NUM_PORTS-1:0] eligible;
  logic                 found;

  assign eligible = req & ~exclude;

`ifdef WR_ARB_ROUND_ROBIN_EN
  // Walk ptr+1, ptr+2, ... wrapping; ptr itself is looked at last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!found && eligible[(int'(ptr) + k) % NUM_PORTS]) begin
        winner[(int'(ptr) + k) % NUM_PORTS] = 1'b1;
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && eligible[i]) begin
        winner[i] = 1'b1;
        found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mp_write_arbiter.sv
// Grants one processor at a time the data-memory write port, with zero-bubble
// handoff between writers. Define WR_ARB_ROUND_ROBIN_EN for rotating priority.
module mp_write_arbiter import pram_pkg::*; #(
  parameter int NUM_PORTS        = DEF_NUM_PORTS,
  parameter int DOUBLEWORD_WIDTH = DEF_DOUBLEWORD_WIDTH,
  parameter int DATA_MEMORY_SIZE = DEF_DATA_MEMORY_SIZE,
  parameter int ADDR_WIDTH_DM    = $clog2(DATA_MEMORY_SIZE),
  parameter int DATA_TYPE_WIDTH  = DEF_DATA_TYPE_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  mp_write_arbiter_if.slave bus
);

  arb_state_t                  state;
  logic [NUM_PORTS-1:0]        grant;
  logic [NUM_PORTS-1:0]        winner;
  logic [NUM_PORTS-1:0]        exclude;
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        idle_p;
  logic [DOUBLEWORD_WIDTH-1:0] data_mux;
  logic [ADDR_WIDTH_DM-1:0]    addr_mux;
  logic [DATA_TYPE_WIDTH-1:0]  type_mux;

  assign req     = bus.wr_ins_p;
  assign exclude = (state == ST_WRITE) ? grant : '0;

`ifdef WR_ARB_ROUND_ROBIN_EN
  localparam int PTR_W = $clog2(NUM_PORTS);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] pick_ptr;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
  end

  // The handoff pick already rotates from the port being released.
  assign pick_ptr = (state == ST_WRITE) ? grant_idx : ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PTR_W'(NUM_PORTS - 1);
    end else if (state == ST_WRITE && bus.wr_idle_dm) begin
      ptr <= grant_idx;
    end
  end

  rr_priority_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req     (req),
    .ptr     (pick_ptr),
    .exclude (exclude),
    .winner  (winner)
  );
`else
  rr_priority_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req     (req),
    .exclude (exclude),
    .winner  (winner)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      grant <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant <= winner;
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!bus.wr_idle_dm) begin
            state <= ST_WRITE;
          end else if (~|(grant & req)) begin
            grant <= '0;
            state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (bus.wr_idle_dm) begin
            if (|(req & ~grant)) begin
              grant <= winner;
              state <= ST_ACCESS;
            end else begin
              grant <= '0;
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Grant is one-hot or zero, so OR-ing the gated slices is a clean mux.
  always_comb begin
    data_mux = '0;
    addr_mux = '0;
    type_mux = '0;
    idle_p   = '1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        data_mux  = data_mux | bus.data_bus_wr_p[i*DOUBLEWORD_WIDTH +: DOUBLEWORD_WIDTH];
        addr_mux  = addr_mux | bus.addr_wr_p[i*ADDR_WIDTH_DM +: ADDR_WIDTH_DM];
        type_mux  = type_mux | bus.data_type_wr_p[i*DATA_TYPE_WIDTH +: DATA_TYPE_WIDTH];
        idle_p[i] = bus.wr_idle_dm;
      end
    end
  end

  assign bus.data_bus_wr_dm  = data_mux;
  assign bus.addr_wr_dm      = addr_mux;
  assign bus.data_type_wr_dm = type_mux;
  assign bus.wr_idle_p       = idle_p;
  assign bus.wr_access_p     = grant;
  assign bus.wr_ins_dm       = |(grant & req);
  assign bus.arb_busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_mp_write_arbiter.sv
// Bench for mp_write_arbiter: directed scenarios plus a random phase, all checked
// against a port-ownership model. Honours WR_ARB_ROUND_ROBIN_EN.
module tb_mp_write_arbiter;

  localparam int NP  = 4;
  localparam int DW  = 64;
  localparam int DMS = 1024;
  localparam int AW  = $clog2(DMS);
  localparam int TW  = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mp_write_arbiter_if #(
    .NUM_PORTS(NP), .DOUBLEWORD_WIDTH(DW), .DATA_MEMORY_SIZE(DMS),
    .ADDR_WIDTH_DM(AW), .DATA_TYPE_WIDTH(TW)
  ) bus ();

  mp_write_arbiter #(
    .NUM_PORTS(NP), .DOUBLEWORD_WIDTH(DW), .DATA_MEMORY_SIZE(DMS),
    .ADDR_WIDTH_DM(AW), .DATA_TYPE_WIDTH(TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Model: which port owns the write port (-1 none) and whether memory went busy.
  int m_owner   = -1;
  bit m_writing = 1'b0;
`ifdef WR_ARB_ROUND_ROBIN_EN
  int m_last    = NP - 1;
`endif
  logic [NP-1:0] m_req;

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int pick(logic [NP-1:0] r, int excl);
`ifdef WR_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NP; k++) begin
      int idx;
      idx = (m_last + k) % NP;
      if (r[idx] && idx != excl) return idx;
    end
`else
    for (int i = 0; i < NP; i++) begin
      if (r[i] && i != excl) return i;
    end
`endif
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner   = -1;
      m_writing = 1'b0;
`ifdef WR_ARB_ROUND_ROBIN_EN
      m_last    = NP - 1;
`endif
    end else begin
      m_req = bus.wr_ins_p;
      if (m_owner < 0) begin
        if (|m_req) begin
          m_owner   = pick(m_req, -1);
          m_writing = 1'b0;
        end
      end else if (!m_writing) begin
        if (!bus.wr_idle_dm) m_writing = 1'b1;
        else if (!m_req[m_owner]) m_owner = -1;
      end else if (bus.wr_idle_dm) begin
`ifdef WR_ARB_ROUND_ROBIN_EN
        m_last = m_owner;
`endif
        m_owner   = pick(m_req, m_owner);
        m_writing = 1'b0;
      end
    end
  end

  logic [NP-1:0] e_acc, e_idle;
  logic [DW-1:0] e_data;
  logic [AW-1:0] e_addr;
  logic [TW-1:0] e_type;
  logic          e_ins;

  always @(negedge clk) begin
    if (chk_en) begin
      e_acc  = '0;
      e_idle = '1;
      e_data = '0;
      e_addr = '0;
      e_type = '0;
      e_ins  = 1'b0;
      if (m_owner >= 0) begin
        e_acc[m_owner]  = 1'b1;
        e_idle[m_owner] = bus.wr_idle_dm;
        e_data = bus.data_bus_wr_p[m_owner*DW +: DW];
        e_addr = bus.addr_wr_p[m_owner*AW +: AW];
        e_type = bus.data_type_wr_p[m_owner*TW +: TW];
        e_ins  = bus.wr_ins_p[m_owner];
      end
      check_output("wr_access_p", bus.wr_access_p, e_acc);
      check_output("wr_idle_p", bus.wr_idle_p, e_idle);
      check_output("wr_ins_dm", bus.wr_ins_dm, e_ins);
      check_output("arb_busy", bus.arb_busy, m_owner >= 0);
      check_output("data_bus_wr_dm", bus.data_bus_wr_dm, e_data);
      check_output("addr_wr_dm", bus.addr_wr_dm, e_addr);
      check_output("data_type_wr_dm", bus.data_type_wr_dm, e_type);
      check_output("grant_onehot", $countones(bus.wr_access_p) <= 1, 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [NP-1:0] req, input logic idle);
    bus.wr_ins_p   = req;
    bus.wr_idle_dm = idle;
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    apply_stimulus('0, 1'b1);
    tick();
    rst_n = 1'b1;
  endtask

  logic [NP-1:0] rr_order [4];

  initial begin
    rst_n = 1'b0;
    bus.data_bus_wr_p  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    bus.addr_wr_p      = {10'd400, 10'd300, 10'd200, 10'd100};
    bus.data_type_wr_p = {2'd3, 2'd2, 2'd1, 2'd0};
    bus.wr_ins_p       = 4'b1111;
    bus.wr_idle_dm     = 1'b1;
    chk_en = 1'b1;
    #2;
    check_output("rst_access", bus.wr_access_p, 4'b0000);
    check_output("rst_idle_p", bus.wr_idle_p, 4'b1111);
    check_output("rst_ins_dm", bus.wr_ins_dm, 1'b0);
    check_output("rst_busy", bus.arb_busy, 1'b0);
    check_output("rst_data", bus.data_bus_wr_dm, 64'h0);
    tick();
    apply_stimulus('0, 1'b1);
    tick();
    rst_n = 1'b1;

    // Single request on port 2
    apply_stimulus(4'b0100, 1'b1);
    check_output("single_pre", bus.wr_access_p, 4'b0000);
    tick();
    check_output("single_grant", bus.wr_access_p, 4'b0100);
    check_output("single_ins_dm", bus.wr_ins_dm, 1'b1);
    check_output("single_data", bus.data_bus_wr_dm, 64'hCCCC_CCCC_CCCC_CCCC);
    check_output("single_addr", bus.addr_wr_dm, 10'd300);
    check_output("single_type", bus.data_type_wr_dm, 2'd2);
    apply_stimulus(4'b0100, 1'b0);
    check_output("single_idle_low", bus.wr_idle_p, 4'b1011);
    tick();
    check_output("single_write", bus.wr_access_p, 4'b0100);
    check_output("single_write_busy", bus.arb_busy, 1'b1);
    apply_stimulus(4'b0000, 1'b1);
    check_output("single_idle_high", bus.wr_idle_p, 4'b1111);
    tick();
    check_output("single_release", bus.wr_access_p, 4'b0000);
    check_output("single_release_busy", bus.arb_busy, 1'b0);

    pulse_reset();
`ifdef WR_ARB_ROUND_ROBIN_EN
    // All four held: rotation 0,1,2,3 with no idle cycle between writes
    rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    apply_stimulus(4'b1111, 1'b1);
    for (int w = 0; w < 4; w++) begin
      tick();
      check_output("rr_grant", bus.wr_access_p, rr_order[w]);
      check_output("rr_busy", bus.arb_busy, 1'b1);
      apply_stimulus(4'b1111, 1'b0);
      tick();
      check_output("rr_write", bus.wr_access_p, rr_order[w]);
      apply_stimulus(4'b1111, 1'b1);
    end
    apply_stimulus(4'b0000, 1'b1);
    tick();
`else
    // All four requesting from idle: port 0 wins each fresh arbitration
    rr_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
    for (int w = 0; w < 4; w++) begin
      apply_stimulus(4'b1111, 1'b1);
      tick();
      check_output("fixed_grant", bus.wr_access_p, rr_order[w]);
      apply_stimulus(4'b1111, 1'b0);
      tick();
      apply_stimulus(4'b0000, 1'b1);
      tick();
      check_output("fixed_release", bus.arb_busy, 1'b0);
    end
`endif

    // Withdrawal of port 1 while memory stays idle
    apply_stimulus(4'b0010, 1'b1);
    tick();
    check_output("wd_grant", bus.wr_access_p, 4'b0010);
    apply_stimulus(4'b0000, 1'b1);
    check_output("wd_ins_dm", bus.wr_ins_dm, 1'b0);
    tick();
    check_output("wd_access", bus.wr_access_p, 4'b0000);
    check_output("wd_busy", bus.arb_busy, 1'b0);

    // Reset in the middle of a write to port 1
    apply_stimulus(4'b0010, 1'b1);
    tick();
    apply_stimulus(4'b0010, 1'b0);
    tick();
    check_output("mid_write_grant", bus.wr_access_p, 4'b0010);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_access", bus.wr_access_p, 4'b0000);
    check_output("mid_rst_idle_p", bus.wr_idle_p, 4'b1111);
    check_output("mid_rst_ins_dm", bus.wr_ins_dm, 1'b0);
    check_output("mid_rst_busy", bus.arb_busy, 1'b0);
    apply_stimulus('0, 1'b1);
    tick();
    rst_n = 1'b1;

    // Random traffic; requests change on roughly a quarter of cycles
    for (int c = 0; c < 10000; c++) begin
      tick();
      if ($urandom_range(0, 3) == 0) bus.wr_ins_p = NP'($urandom);
      bus.wr_idle_dm = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        for (int i = 0; i < NP*DW/32; i++) bus.data_bus_wr_p[i*32 +: 32] = $urandom;
        for (int i = 0; i < NP; i++) bus.addr_wr_p[i*AW +: AW] = AW'($urandom);
        for (int i = 0; i < NP; i++) bus.data_type_wr_p[i*TW +: TW] = TW'($urandom);
      end
    end
    tick();
    tick();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
